// File: rtl/rdma_rx_psn_check.sv
// RoCE RX PSN checker: classifies each packet against a per-QP expected PSN,
// forwards in-order/bypass traffic, drops the rest and queues ACK/NAK events.
module rdma_rx_psn_check #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_USER_WIDTH = 96,
  parameter int QP_AWIDTH       = 4,
  parameter int EVT_FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
  input  logic                       cfg_wen,
  input  logic [QP_AWIDTH-1:0]       cfg_addr,
  input  logic [23:0]                cfg_wdata,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [23:0]                evt_qpn,
  output logic [23:0]                evt_psn,
  output logic [1:0]                 evt_syndrome,
  output logic [31:0]                drop_cnt,
  output logic [31:0]                evt_lost_cnt
);

  localparam int QP_N = 1 << QP_AWIDTH;
  localparam int EW   = $clog2(EVT_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t state_q, state_d;

  logic                 m_valid_q;
  logic                 s_ready;
  logic                 s_hs;
  logic                 beat0;
  logic [23:0]          qpn;
  logic [23:0]          psn;
  logic [QP_AWIDTH-1:0] idx;
  logic [23:0]          exp_q [QP_N];
  logic [QP_N-1:0]      nak_q;
  logic [23:0]          cur_exp;
  logic [23:0]          diff;
  logic [15:0]          keep_ones;
  logic                 bypass;
  logic                 in_order;
  logic                 ahead;
  logic                 dup;
  logic                 pass0;
  logic                 pass_beat;
  logic [23:0]          pkt_qpn_q;
  logic [23:0]          pkt_psn_q;
  logic                 ack_pend_q;

  logic                 push;
  logic [49:0]          push_rec;
  logic                 pop;
  logic                 full;
  logic [EW:0]          wr_ptr_q;
  logic [EW:0]          rd_ptr_q;
  logic [EW:0]          fill;
  logic [49:0]          fifo_q [EVT_FIFO_DEPTH];
  logic [49:0]          rd_rec;

  assign s_ready       = !m_valid_q || m_axis_tready;
  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid_q;
  assign s_hs          = s_axis_tvalid && s_ready;
  assign beat0         = s_hs && (state_q == IDLE);

  assign qpn     = s_axis_tdata[391:368];
  assign psn     = s_axis_tdata[423:400];
  assign idx     = qpn[QP_AWIDTH-1:0];
  assign cur_exp = exp_q[idx];
  assign diff    = psn - cur_exp;

  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
      keep_ones = keep_ones + 16'(s_axis_tkeep[i]);
  end

  assign bypass   = keep_ones < 16'd62;
  assign in_order = diff == 24'd0;
  assign ahead    = !in_order && !diff[23];
  assign dup      = diff[23];
  assign pass0    = bypass || in_order;

  always_comb begin
    state_d   = state_q;
    pass_beat = 1'b0;
    unique case (state_q)
      IDLE: begin
        pass_beat = pass0;
        if (s_hs && !s_axis_tlast)
          state_d = pass0 ? FWD : DROP;
      end
      FWD: begin
        pass_beat = 1'b1;
        if (s_hs && s_axis_tlast)
          state_d = IDLE;
      end
      DROP: begin
        if (s_hs && s_axis_tlast)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    unique case (1'b1)
      beat0 && !bypass && in_order && s_axis_tlast: begin
        push     = 1'b1;
        push_rec = {2'b00, psn, qpn};
      end
      beat0 && !bypass && ahead && !nak_q[idx]: begin
        push     = 1'b1;
        push_rec = {2'b01, cur_exp, qpn};
      end
      beat0 && !bypass && dup: begin
        push     = 1'b1;
        push_rec = {2'b10, cur_exp - 24'd1, qpn};
      end
      s_hs && (state_q == FWD) && s_axis_tlast && ack_pend_q: begin
        push     = 1'b1;
        push_rec = {2'b00, pkt_psn_q, pkt_qpn_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkt_qpn_q  <= '0;
      pkt_psn_q  <= '0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat0) begin
        pkt_qpn_q  <= qpn;
        pkt_psn_q  <= psn;
        ack_pend_q <= !bypass && in_order;
      end
    end
  end

  // cfg write is applied last so it overrides a same-entry packet update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QP_N; i++)
        exp_q[i] <= '0;
      nak_q <= '0;
    end else begin
      if (beat0 && !bypass) begin
        if (in_order) begin
          exp_q[idx] <= psn + 24'd1;
          nak_q[idx] <= 1'b0;
        end else if (ahead) begin
          nak_q[idx] <= 1'b1;
        end
      end
      if (cfg_wen) begin
        exp_q[cfg_addr] <= cfg_wdata;
        nak_q[cfg_addr] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (beat0 && !pass0 && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= '0;
    end else if (s_ready) begin
      m_valid_q <= s_hs && pass_beat;
      if (s_hs && pass_beat) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tuser <= s_axis_tuser;
      end
    end
  end

  assign fill      = wr_ptr_q - rd_ptr_q;
  assign full      = fill == (EW+1)'(EVT_FIFO_DEPTH);
  assign evt_valid = wr_ptr_q != rd_ptr_q;
  assign pop       = evt_valid && evt_ready;
  assign rd_rec    = fifo_q[rd_ptr_q[EW-1:0]];

  assign evt_qpn      = rd_rec[23:0];
  assign evt_psn      = rd_rec[47:24];
  assign evt_syndrome = rd_rec[49:48];

  // a pop in the same cycle frees the slot, so full+pop still accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      evt_lost_cnt <= '0;
      for (int i = 0; i < EVT_FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && (!full || pop)) begin
        fifo_q[wr_ptr_q[EW-1:0]] <= push_rec;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (push && full && !pop && (evt_lost_cnt != '1))
        evt_lost_cnt <= evt_lost_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rdma_rx_psn_check.sv
// Directed bench for rdma_rx_psn_check: expected beats and events are
// queued as stimulus is driven and retired by monitors on the outputs.
module tb_rdma_rx_psn_check;

  localparam int DW = 512;
  localparam int KW = DW/8;
  localparam int UW = 96;
  localparam int QA = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          cfg_wen = 1'b0;
  logic [QA-1:0] cfg_addr = '0;
  logic [23:0]   cfg_wdata = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [23:0]   evt_qpn;
  logic [23:0]   evt_psn;
  logic [1:0]    evt_syndrome;
  logic [31:0]   drop_cnt;
  logic [31:0]   evt_lost_cnt;

  beat_t       exp_beats [$];
  logic [49:0] exp_evts [$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        rnd_ready = 1'b0;
  logic        stall_prev = 1'b0;
  logic [49:0] prev_evt = '0;
  beat_t       mon_b;
  beat_t       mon_e;
  logic [49:0] mon_ev;
  logic [49:0] mon_got;

  rdma_rx_psn_check #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_USER_WIDTH(UW),
    .QP_AWIDTH(QA),
    .EVT_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .cfg_wen(cfg_wen),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_qpn(evt_qpn),
    .evt_psn(evt_psn),
    .evt_syndrome(evt_syndrome),
    .drop_cnt(drop_cnt),
    .evt_lost_cnt(evt_lost_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    else m_axis_tready = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        n_chk++;
        mon_b = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (exp_beats.size() == 0) begin
          n_fail++;
          $error("FAIL out_beat: observed extra beat data_lo=%h, expected none",
                 mon_b.d[63:0]);
        end else begin
          mon_e = exp_beats.pop_front();
          assert (mon_b === mon_e) else begin
            n_fail++;
            $error("FAIL out_beat: observed lo=%h k=%h l=%b, expected lo=%h k=%h l=%b",
                   mon_b.d[63:0], mon_b.k, mon_b.l, mon_e.d[63:0], mon_e.k, mon_e.l);
          end
        end
      end
      mon_got = {evt_syndrome, evt_psn, evt_qpn};
      if (stall_prev) begin
        n_chk++;
        assert (mon_got === prev_evt) else begin
          n_fail++;
          $error("FAIL evt_stable: observed %h, expected %h", mon_got, prev_evt);
        end
      end
      if (evt_valid && evt_ready) begin
        n_chk++;
        if (exp_evts.size() == 0) begin
          n_fail++;
          $error("FAIL evt: observed extra %h, expected none", mon_got);
        end else begin
          mon_ev = exp_evts.pop_front();
          assert (mon_got === mon_ev) else begin
            n_fail++;
            $error("FAIL evt: observed %h, expected %h", mon_got, mon_ev);
          end
        end
      end
      stall_prev = evt_valid && !evt_ready;
      prev_evt   = mon_got;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [49:0] ev(input logic [23:0] q,
                                     input logic [23:0] p,
                                     input logic [1:0] s);
    return {s, p, q};
  endfunction

  task automatic cfg(input logic [QA-1:0] a, input logic [23:0] v);
    cfg_wen   = 1'b1;
    cfg_addr  = a;
    cfg_wdata = v;
    @(posedge clk);
    #1;
    cfg_wen = 1'b0;
  endtask

  task automatic send(input logic [23:0] q, input logic [23:0] p,
                      input int nb, input logic [KW-1:0] k0,
                      input logic fwd, input logic has_evt,
                      input logic [49:0] e, input logic nostall);
    beat_t b;
    logic  hs;
    int    t;
    if (has_evt) exp_evts.push_back(e);
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom();
      for (int w = 0; w < UW/32; w++) b.u[w*32 +: 32] = $urandom();
      b.k = {$urandom(), $urandom()};
      b.l = (i == nb-1);
      if (i == 0) begin
        b.d[391:368] = q;
        b.d[423:400] = p;
        b.k = k0;
      end
      if (fwd) exp_beats.push_back(b);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_tuser  = b.u;
      t = 0;
      do begin
        @(negedge clk);
        hs = s_axis_tready;
        if (nostall && t == 0) chk("no_stall", 64'(hs), 64'd1);
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 200);
      if (!hs) chk("s_tready_timeout", 64'(hs), 64'd1);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_beats.size() != 0 || exp_evts.size() != 0) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_beats", 64'(exp_beats.size()), 64'd0);
    chk("drain_evts", 64'(exp_evts.size()), 64'd0);
  endtask

  localparam logic [KW-1:0] FULL = '1;
  localparam logic [KW-1:0] K61  = {3'b000, {61{1'b1}}};
  localparam logic [KW-1:0] K62  = {2'b00, {62{1'b1}}};

  int          exp_drop;
  logic [23:0] e8;
  logic        nak8;
  int          r;
  int          nb;
  logic [23:0] p;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_lost_cnt", 64'(evt_lost_cnt), 64'd0);
    chk("rst_s_ready", 64'(s_axis_tready), 64'd1);

    send(24'd3, 24'd0, 3, FULL, 1, 1, ev(24'd3, 24'd0, 2'b00), 0);
    send(24'd3, 24'd1, 3, FULL, 1, 1, ev(24'd3, 24'd1, 2'b00), 0);
    send(24'd3, 24'd2, 1, FULL, 1, 1, ev(24'd3, 24'd2, 2'b00), 0);
    wait_drain();

    cfg(4'd5, 24'hFFFFFF);
    send(24'd5, 24'hFFFFFF, 2, FULL, 1, 1, ev(24'd5, 24'hFFFFFF, 2'b00), 0);
    send(24'd5, 24'd0, 1, FULL, 1, 1, ev(24'd5, 24'd0, 2'b00), 0);
    send(24'd5, 24'd1, 1, FULL, 1, 1, ev(24'd5, 24'd1, 2'b00), 0);
    wait_drain();

    cfg(4'd2, 24'd10);
    send(24'd2, 24'd12, 3, FULL, 0, 1, ev(24'd2, 24'd10, 2'b01), 0);
    send(24'd2, 24'd13, 2, FULL, 0, 0, '0, 0);
    chk("drop_cnt_ahead", 64'(drop_cnt), 64'd2);
    send(24'd2, 24'd10, 2, FULL, 1, 1, ev(24'd2, 24'd10, 2'b00), 0);
    send(24'd2, 24'd13, 1, FULL, 0, 1, ev(24'd2, 24'd11, 2'b01), 0);
    chk("drop_cnt_renak", 64'(drop_cnt), 64'd3);
    wait_drain();

    cfg(4'd2, 24'd10);
    send(24'd2, 24'd7, 1, FULL, 0, 1, ev(24'd2, 24'd9, 2'b10), 0);
    send(24'd2, 24'd500, 2, K61, 1, 0, '0, 0);
    chk("drop_cnt_bypass", 64'(drop_cnt), 64'd4);
    send(24'd2, 24'd500, 2, K62, 0, 1, ev(24'd2, 24'd10, 2'b01), 0);
    chk("drop_cnt_k62", 64'(drop_cnt), 64'd5);
    wait_drain();

    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(24'd7, 24'(i), 1, FULL, 1, i < 4, ev(24'd7, 24'(i), 2'b00), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("evt_lost_cnt", 64'(evt_lost_cnt), 64'd2);
    chk("evt_valid_full", 64'(evt_valid), 64'd1);
    evt_ready = 1'b1;
    send(24'd7, 24'd6, 1, FULL, 1, 1, ev(24'd7, 24'd6, 2'b00), 1);
    wait_drain();
    chk("evt_lost_pushpop", 64'(evt_lost_cnt), 64'd2);

    exp_drop  = 5;
    e8        = 24'd0;
    nak8      = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      r  = $urandom_range(0, 4);
      nb = $urandom_range(1, 4);
      if (r <= 2) begin
        send(24'd8, e8, nb, FULL, 1, 1, ev(24'd8, e8, 2'b00), 0);
        e8   = e8 + 24'd1;
        nak8 = 1'b0;
      end else if (r == 3) begin
        p = e8 + 24'd3;
        send(24'd8, p, nb, FULL, 0, !nak8, ev(24'd8, e8, 2'b01), 0);
        nak8 = 1'b1;
        exp_drop++;
      end else begin
        p = e8 - 24'd1;
        send(24'd8, p, nb, FULL, 0, 1, ev(24'd8, e8 - 24'd1, 2'b10), 0);
        exp_drop++;
      end
    end
    rnd_ready = 1'b0;
    wait_drain();
    chk("drop_cnt_random", 64'(drop_cnt), 64'(exp_drop));

    evt_ready     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tdata[391:368] = 24'd9;
    s_axis_tdata[423:400] = 24'd5;
    s_axis_tkeep  = FULL;
    s_axis_tlast  = 1'b0;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_rst_drop", 64'(drop_cnt), 64'd0);
    chk("async_rst_evt", 64'(evt_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    send(24'd9, 24'd0, 1, FULL, 1, 1, ev(24'd9, 24'd0, 2'b00), 0);
    send(24'd2, 24'd0, 2, FULL, 1, 1, ev(24'd2, 24'd0, 2'b00), 0);
    wait_drain();
    chk("drop_cnt_after_rst", 64'(drop_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rdma_rx_psn_check.md
RDMA_RX_PSN_CHECK -- requirements
Module: rdma_rx_psn_check

Interface
REQ-001 The block SHALL have these parameters, one per line:
- AXIS_DATA_WIDTH, 512: tdata width (minimum 512).
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8: tkeep width.
- AXIS_USER_WIDTH, 96: tuser width.
- QP_AWIDTH, 4: QP table index width (2^QP_AWIDTH entries).
- EVT_FIFO_DEPTH, 4: ACK/NAK event FIFO depth (power of 2).

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: the only clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser, in/in/in/out/in/in, widths per parameters: RX stream carrying full RoCE headers.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser, out/out/out/in/out/out, widths per parameters: checked stream.
- cfg_wen, in, 1: expected-PSN table write strobe.
- cfg_addr, in, QP_AWIDTH: QP table index to write.
- cfg_wdata, in, 24: expected PSN value to write.
- evt_valid, out, 1: event FIFO has an entry.
- evt_ready, in, 1: event sink ready.
- evt_qpn, out, 24: event QPN.
- evt_psn, out, 24: event PSN.
- evt_syndrome, out, 2: 00 ACK, 01 NAK-sequence, 10 duplicate-ACK.
- drop_cnt, out, 32: dropped packet count.
- evt_lost_cnt, out, 32: lost event count.

Function
REQ-003 The first beat of a packet (beat 0) SHALL be parsed as follows: dest QPN = tdata[391:368], PSN = tdata[423:400]; table index = QPN[QP_AWIDTH-1:0].
REQ-004 A packet whose beat-0 tkeep has fewer than 62 ones SHALL bypass the check: it is forwarded unchanged and produces no event.
REQ-005 The classification SHALL use diff = (PSN - exp[idx]) mod 2^24:
- diff == 0: IN_ORDER.
- 1 <= diff < 2^23: AHEAD.
- otherwise: DUPLICATE.
REQ-006 An IN_ORDER packet SHALL be forwarded whole; exp[idx] <= PSN+1 mod 2^24 (0xFFFFFF wraps to 0); nak_sent[idx] is cleared; one ACK event (qpn, PSN) is pushed on the handshake of its last beat.
REQ-007 An AHEAD packet SHALL be dropped whole. If nak_sent[idx] is 0, one NAK event (qpn, exp[idx]) is pushed and nak_sent[idx] is set. If nak_sent[idx] is already 1, no event is pushed.
REQ-008 A DUPLICATE packet SHALL be dropped whole, and one duplicate-ACK event (qpn, exp[idx]-1 mod 2^24) is pushed.
REQ-009 drop_cnt SHALL increment once per dropped packet, on its beat-0 handshake, and saturate at 0xFFFFFFFF.
REQ-010 The block SHALL run a per-packet FSM with states IDLE, FWD and DROP:
- IDLE to FWD on beat-0 handshake without tlast, for bypass or IN_ORDER.
- IDLE to DROP on beat-0 handshake without tlast, for AHEAD or DUPLICATE.
- FWD or DROP back to IDLE on the tlast handshake.
- A single-beat packet stays in IDLE.
REQ-011 The forward path SHALL be one register stage: tdata, tkeep, tlast and tuser are unmodified, with latency 1 cycle from input handshake to m_axis_tvalid.
REQ-012 s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready. Dropped beats are consumed under the same condition and never assert m_axis_tvalid.
REQ-013 A cfg_wen write SHALL set exp[cfg_addr] <= cfg_wdata and clear nak_sent[cfg_addr]. If it coincides with a packet update of the same entry, the cfg write wins.
REQ-014 A table read SHALL return the value written by any update completed in an earlier cycle (back-to-back packets on the same QP see the updated exp).
REQ-015 The event FIFO SHALL use a valid/ready handshake, and evt_* SHALL stay stable while evt_valid is high and evt_ready is low.
REQ-016 On a push to a full event FIFO, the event SHALL be discarded and evt_lost_cnt incremented (saturating). Packet forwarding is never stalled by the event FIFO.
REQ-017 A simultaneous push and pop on a full FIFO SHALL be accepted without loss.

Reset
REQ-018 When rst_n is low, asynchronously, the block SHALL set:
- FSM to IDLE.
- m_axis_tvalid = 0, evt_valid = 0.
- all exp = 0, all nak_sent = 0.
- event FIFO empty.
- drop_cnt = 0, evt_lost_cnt = 0.
REQ-019 A packet in flight when reset asserts SHALL be abandoned. After rst_n rises, the next beat with s_axis_tvalid high is treated as beat 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- After reset, QPN 0x000003 PSN 0, then PSN 1, each 3 beats -> both forwarded; exp[3] = 2; two ACK events with PSN 0 and 1.
- cfg write exp[5] = 0xFFFFFF; QP5 PSN 0xFFFFFF, then PSN 0 -> both forwarded; exp[5] = 1.
- exp[2] = 10; QP2 PSN 12, then PSN 13 -> both dropped; exactly one NAK event with PSN 10; drop_cnt = 2. Then PSN 10 -> forwarded; nak_sent cleared.
- exp[2] = 10; PSN 7 -> dropped; duplicate-ACK event with PSN 9.
- evt_ready held low for 6 in-order single-beat packets -> 4 events queued; evt_lost_cnt = 2; data path never stalls.
- m_axis_tready toggled randomly -> output stream bit-exact with input minus dropped packets; no beat duplicated or lost.
